// File: rtl/axi4_wr_aux_gen_no_resp.sv
// AXI4 write-address generator: turns one {id, addr, len} descriptor into one AW
// transaction and holds stream_en open until that burst's last W beat is accepted.
module axi4_wr_aux_gen_no_resp #(
  parameter int DSIZE  = 256,
  parameter int IDSIZE = 4,
  parameter int ASIZE  = 32,
  parameter int LSIZE  = 8
) (
  input  logic                            axi_aclk,
  input  logic                            axi_aresetn,
  input  logic                            id_add_len_in_tvalid,
  input  logic [IDSIZE+ASIZE+LSIZE-1:0]   id_add_len_in_tdata,
  input  logic                            id_add_len_in_tlast,
  output logic                            id_add_len_in_tready,
  output logic [IDSIZE-1:0]               axi_awid,
  output logic [ASIZE-1:0]                axi_awaddr,
  output logic [LSIZE-1:0]                axi_awlen,
  output logic [2:0]                      axi_awsize,
  output logic [1:0]                      axi_awburst,
  output logic                            axi_awlock,
  output logic [3:0]                      axi_awcache,
  output logic [2:0]                      axi_awprot,
  output logic [3:0]                      axi_awqos,
  output logic                            axi_awvalid,
  input  logic                            axi_awready,
  input  logic                            axi_wvalid,
  input  logic                            axi_wready,
  input  logic                            axi_wlast,
  output logic                            stream_en
);

  localparam int DW     = IDSIZE + ASIZE + LSIZE;
  localparam int AWSIZE = $clog2(DSIZE / 8);

  typedef enum logic [1:0] {S_IDLE, S_AW, S_DATA} state_t;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic [IDSIZE-1:0]  awid_q, awid_d;
  logic [ASIZE-1:0]   awaddr_q, awaddr_d;
  logic [LSIZE-1:0]   awlen_q, awlen_d;
  logic               w_last_hs;
  logic               unused_tlast;

  assign unused_tlast = id_add_len_in_tlast;
  assign w_last_hs    = axi_wvalid & axi_wready & axi_wlast;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      awid_q   <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      awid_q   <= awid_d;
      awaddr_q <= awaddr_d;
      awlen_q  <= awlen_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    awid_d   = awid_q;
    awaddr_d = awaddr_q;
    awlen_d  = awlen_q;
    case (state_q)
      S_IDLE: begin
        done_d = 1'b0;
        if (id_add_len_in_tvalid) begin
          awlen_d  = id_add_len_in_tdata[LSIZE-1:0];
          awaddr_d = id_add_len_in_tdata[LSIZE+ASIZE-1:LSIZE];
          awid_d   = id_add_len_in_tdata[DW-1:LSIZE+ASIZE];
          state_d  = S_AW;
        end
      end
      S_AW: begin
        // W data may finish before the address is taken; remember it so AW exits straight to IDLE.
        if (axi_awready) begin
          done_d  = 1'b0;
          state_d = (w_last_hs || done_q) ? S_IDLE : S_DATA;
        end else if (w_last_hs) begin
          done_d = 1'b1;
        end
      end
      S_DATA: begin
        if (w_last_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign id_add_len_in_tready = (state_q == S_IDLE) & axi_aresetn;
  assign axi_awvalid          = (state_q == S_AW);
  assign stream_en            = (state_q != S_IDLE);

  assign axi_awid    = awid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awsize  = 3'(AWSIZE);
  assign axi_awburst = 2'b01;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = 4'b0000;
  assign axi_awprot  = 3'b000;
  assign axi_awqos   = 4'b0000;

endmodule

// File: tb/tb_axi4_wr_aux_gen_no_resp.sv
// Randomized bench for axi4_wr_aux_gen_no_resp against a burst-level reference model.
module tb_axi4_wr_aux_gen_no_resp;

  localparam int DSIZE  = 256;
  localparam int IDSIZE = 4;
  localparam int ASIZE  = 32;
  localparam int LSIZE  = 8;
  localparam int TW     = IDSIZE + ASIZE + LSIZE;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tvalid, tlast, tready;
  logic [TW-1:0]     tdata;
  logic [IDSIZE-1:0] awid;
  logic [ASIZE-1:0]  awaddr;
  logic [LSIZE-1:0]  awlen;
  logic [2:0]        awsize, awprot;
  logic [1:0]        awburst;
  logic              awlock, awvalid, awready;
  logic [3:0]        awcache, awqos;
  logic              wvalid, wready, wlast, stream_en;

  always #5 clk = ~clk;

  axi4_wr_aux_gen_no_resp #(.DSIZE(DSIZE), .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .id_add_len_in_tvalid(tvalid), .id_add_len_in_tdata(tdata),
    .id_add_len_in_tlast(tlast), .id_add_len_in_tready(tready),
    .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
    .axi_awburst(awburst), .axi_awlock(awlock), .axi_awcache(awcache),
    .axi_awprot(awprot), .axi_awqos(awqos), .axi_awvalid(awvalid),
    .axi_awready(awready), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_wlast(wlast), .stream_en(stream_en)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: a burst is "busy" from the cycle after acceptance until the
  // cycle after both its address has been taken and its last data beat has been seen.
  bit            m_busy, m_aw, m_wdone;
  logic [TW-1:0] m_desc;
  logic [TW-1:0] desc_q[$];
  logic [TW-1:0] exp_aw_q[$];
  int            beat, aw_wait, aw_count;
  int            t_pct, aw_pct, w_pct, aw_delay;

  function automatic logic [TW-1:0] mk(input int id, input logic [31:0] addr, input int len);
    logic [TW-1:0] d;
    d = {IDSIZE'(id), ASIZE'(addr), LSIZE'(len)};
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_aw = 0; m_wdone = 0; beat = 0; aw_wait = 0;
    desc_q.delete();
    exp_aw_q.delete();
  endtask

  task automatic drive();
    tvalid  = (desc_q.size() > 0) && ($urandom_range(99) < t_pct);
    tdata   = (desc_q.size() > 0) ? desc_q[0] : TW'($urandom);
    tlast   = 1'($urandom);
    awready = (aw_wait >= aw_delay) && ($urandom_range(99) < aw_pct);
    wvalid  = m_busy && !m_wdone && ($urandom_range(99) < w_pct);
    wready  = ($urandom_range(99) < w_pct);
    wlast   = wvalid && (beat == int'(m_desc[LSIZE-1:0]));
  endtask

  task automatic step();
    bit acc, awhs, whs;
    logic [TW-1:0] e;
    @(negedge clk);
    chk("tready", tready, !m_busy);
    chk("awvalid", awvalid, m_aw);
    chk("stream_en", stream_en, m_busy);
    chk("aw_const", {awburst, awlock, awcache, awprot, awqos, awsize},
        {2'b01, 1'b0, 4'b0000, 3'b000, 4'b0000, 3'd5});
    if (m_aw) chk("aw_fields_stable", {awid, awaddr, awlen}, m_desc);
    acc  = tvalid && !m_busy;
    awhs = m_aw && awready;
    whs  = m_busy && !m_wdone && wvalid && wready;
    if (awhs) begin
      aw_count++;
      e = exp_aw_q.size() > 0 ? exp_aw_q.pop_front() : 'x;
      chk("aw_handshake", {awid, awaddr, awlen}, e);
    end
    @(posedge clk);
    if (acc) begin
      m_busy = 1; m_aw = 1; m_wdone = 0; m_desc = tdata; beat = 0; aw_wait = 0;
      exp_aw_q.push_back(tdata);
      void'(desc_q.pop_front());
    end else if (m_busy) begin
      if (m_aw) aw_wait++;
      if (awhs) m_aw = 0;
      if (whs) begin
        if (wlast) m_wdone = 1;
        else beat++;
      end
      if (!m_aw && m_wdone) m_busy = 0;
    end
    #1 drive();
  endtask

  task automatic run(input string tag, input int maxc);
    int n;
    n = 0;
    while ((desc_q.size() > 0 || m_busy) && n < maxc) begin
      step();
      n++;
    end
    tests++;
    assert (n < maxc) else begin
      fails++;
      $error("FAIL %s timeout observed=%0d cycles expected<%0d", tag, n, maxc);
    end
    repeat (2) step();
  endtask

  task automatic knobs(input int t, input int a, input int w, input int d);
    t_pct = t; aw_pct = a; w_pct = w; aw_delay = d;
  endtask

  initial begin
    int c0, n;
    model_reset();
    m_desc = '0;
    aw_count = 0;
    knobs(100, 100, 100, 0);
    rst_n = 0; tvalid = 1; tdata = mk(5, 32'hdead, 9); tlast = 0;
    awready = 1; wvalid = 0; wready = 0; wlast = 0;

    // Reset with a pending descriptor
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", tready, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_stream_en", stream_en, 0);
    chk("rst_aw_fields", {awid, awaddr, awlen}, 0);
    tvalid = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 drive();
    repeat (4) step();

    // Single descriptor, full-rate AW and W
    c0 = aw_count;
    desc_q.push_back(mk(3, 32'h1000, 15));
    run("single", 200);
    chk("single_aw_count", aw_count - c0, 1);

    // AW backpressure for 5 cycles
    c0 = aw_count;
    knobs(100, 100, 0, 5);
    desc_q.push_back(mk(7, 32'h2040, 2));
    n = 0;
    while (!m_aw && n < 20) begin step(); n++; end
    knobs(100, 100, 100, 5);
    run("aw_backpressure", 200);
    chk("bp_aw_count", aw_count - c0, 1);

    // Single-beat burst with wlast alongside awready
    c0 = aw_count;
    knobs(100, 100, 100, 0);
    desc_q.push_back(mk(9, 32'h40, 0));
    run("len0_same_cycle", 100);
    chk("len0_aw_count", aw_count - c0, 1);

    // Single-beat burst with wlast before awready
    c0 = aw_count;
    knobs(100, 100, 100, 3);
    desc_q.push_back(mk(2, 32'h80, 0));
    run("early_wlast", 100);
    chk("early_aw_count", aw_count - c0, 1);

    // Two queued descriptors back to back
    c0 = aw_count;
    knobs(100, 100, 100, 0);
    desc_q.push_back(mk(0, 32'h0, 3));
    desc_q.push_back(mk(1, 32'h100, 7));
    run("back_to_back", 300);
    chk("b2b_aw_count", aw_count - c0, 2);

    // Randomized traffic, two flavours
    c0 = aw_count;
    knobs(70, 50, 60, 0);
    for (int i = 0; i < 40; i++) desc_q.push_back(mk($urandom_range(15), $urandom, $urandom_range(12)));
    run("random_a", 20000);
    knobs(90, 20, 100, 0);
    for (int i = 0; i < 40; i++) desc_q.push_back(mk($urandom_range(15), $urandom, $urandom_range(3)));
    run("random_b", 20000);
    chk("random_aw_count", aw_count - c0, 80);
    chk("aw_queue_empty", exp_aw_q.size(), 0);

    // Reset while in the data phase
    knobs(100, 100, 30, 0);
    desc_q.push_back(mk(4, 32'h3000, 20));
    n = 0;
    while (!(m_busy && !m_aw) && n < 50) begin step(); n++; end
    chk("reached_data_phase", {m_busy, m_aw}, 2'b10);
    #2 rst_n = 0;
    #1;
    chk("midrst_tready", tready, 0);
    chk("midrst_awvalid", awvalid, 0);
    chk("midrst_stream_en", stream_en, 0);
    chk("midrst_aw_fields", {awid, awaddr, awlen}, 0);
    model_reset();
    tvalid = 0; wvalid = 0; wready = 0; wlast = 0; awready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 drive();
    c0 = aw_count;
    knobs(100, 100, 100, 0);
    desc_q.push_back(mk(6, 32'h5000, 4));
    run("after_reset", 100);
    chk("after_reset_aw_count", aw_count - c0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
